// File: rtl/rv32i_types.sv
// Shared type definitions for the cache-side memory subsystem.
//
// Contents:
//   LINE_W_DEF  - default cache line width in bits
//   arb_state_t - cache_arbiter FSM states (IDLE, SERVE_I, SERVE_D)
//   arb_grant_t - which cache owns the memory port (GRANT_I, GRANT_D)
//   arb_op_t    - memory operation latched at grant time (read or write-back)
package rv32i_types;

  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance-counter style event counting.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears the count
//   inc   - count one event this cycle
//   count - current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_full;

  // Once every bit is set the counter stops, so a long-running event never
  // wraps back to a misleadingly small value.
  assign w_full = &r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/cache_arbiter.sv
// Two-to-one arbiter sharing the single memory (L2/burst) port between the
// instruction cache and the data cache.  One transaction is in flight at a
// time; under contention the grant alternates so neither cache starves.
//
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   i_read/i_address  - I-cache line-read request (held until i_resp)
//   i_rdata/i_resp    - line data and one-cycle completion pulse to I-cache
//   d_read/d_write    - D-cache line-read / write-back request (held until d_resp)
//   d_address/d_wdata - D-cache line address and write-back data
//   d_rdata/d_resp    - line data and one-cycle completion pulse to D-cache
//   mem_read/mem_write/mem_address/mem_wdata - memory command, driven from
//                       registers only (no combinational path from caches)
//   mem_rdata/mem_resp - memory read data and one-cycle completion
//   contention_cnt    - saturating count of IDLE cycles with both caches pending
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = LINE_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [CNT_W-1:0]  contention_cnt
);

  arb_state_t        r_state;
  arb_grant_t        r_last_grant;
  arb_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_mem_read;
  logic              r_mem_write;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_contend;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // I wins only if it is alone or D had the previous grant; otherwise D goes.
  // With last_grant reset to I, the first tie goes to D.
  assign w_grant_i = w_i_req && (!w_d_req || (r_last_grant == GRANT_D));

  assign w_contend = (r_state == IDLE) && w_i_req && w_d_req;

  // Main FSM.  The memory command flags are registered alongside the state
  // so the memory port never sees a combinational path from the cache
  // request inputs, and an asynchronous reset drops them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_I;
      r_op         <= OP_READ;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state      <= SERVE_I;
            r_last_grant <= GRANT_I;
            r_op         <= OP_READ;
            r_addr       <= i_address;
            r_mem_read   <= 1'b1;
            r_mem_write  <= 1'b0;
          end else if (w_d_req) begin
            r_state      <= SERVE_D;
            r_last_grant <= GRANT_D;
            r_addr       <= d_address;
            // A write-back takes priority over a read raised alongside it.
            if (d_write) begin
              r_op        <= OP_WRITE;
              r_wdata     <= d_wdata;
              r_mem_read  <= 1'b0;
              r_mem_write <= 1'b1;
            end else begin
              r_op        <= OP_READ;
              r_mem_read  <= 1'b1;
              r_mem_write <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          // Always pass back through IDLE so the other side gets a chance.
          if (mem_resp) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_addr;
  assign mem_wdata   = r_wdata;

  // Completion is forwarded combinationally so the cache sees it in the same
  // cycle as memory; a mem_resp arriving in IDLE matches neither state.
  assign i_resp = (r_state == SERVE_I) && mem_resp;
  assign d_resp = (r_state == SERVE_D) && mem_resp;

  // Both caches see the raw read data; each qualifies it with its own resp.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  sat_counter #(
    .W(CNT_W)
  ) u_contention_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_contend),
    .count (contention_cnt)
  );

endmodule
